// File: rtl/ct_mmu_sysmap_arb.sv
// ct_mmu_sysmap_arb: round-robin arbiter sequencing one shared sysmap lookup port (MMU_SYSMAP_MULTIHIT_CHK_EN adds a one-hot hit check on rsp_err)
module ct_mmu_sysmap_arb #(
   parameter int NUM_REQ = 3,
   parameter int PA_W    = 28,
   parameter int FLG_W   = 5,
   parameter int HIT_W   = 8
) (
   input  logic                    forever_cpuclk,
   input  logic                    cpurst_b,
   input  logic                    mmu_flush,
   input  logic [NUM_REQ-1:0]      req_vld,
   input  logic [NUM_REQ*PA_W-1:0] req_pa,
   output logic [NUM_REQ-1:0]      req_gnt,
   output logic                    rsp_vld,
   output logic [1:0]              rsp_id,
   output logic [FLG_W-1:0]        rsp_flg,
   output logic [HIT_W-1:0]        rsp_hit,
   output logic                    rsp_err,
   input  logic                    rsp_ack,
   output logic [PA_W-1:0]         mmu_sysmap_pa_y,
   input  logic [FLG_W-1:0]        sysmap_mmu_flg_y,
   input  logic [HIT_W-1:0]        sysmap_mmu_hit_y
);
   typedef enum logic [1:0] {IDLE, LOOKUP, RESP} state_t;
   state_t            state_q, state_d;
   logic [1:0]        rr_q, rr_d, id_q, id_d, nx1, nx2, win;
   logic [PA_W-1:0]   pa_q, pa_d;
   logic [FLG_W-1:0]  flg_q, flg_d;
   logic [HIT_W-1:0]  hit_q, hit_d;
   logic              vld_q, vld_d, take, lookup;
   assign nx1     = (rr_q == 2'd2) ? 2'd0 : rr_q + 2'd1;
   assign nx2     = (nx1 == 2'd2) ? 2'd0 : nx1 + 2'd1;
   assign win     = req_vld[rr_q] ? rr_q : req_vld[nx1] ? nx1 : nx2;
   assign take    = cpurst_b && state_q == IDLE && !mmu_flush && |req_vld;
   assign lookup  = state_q == LOOKUP && !mmu_flush;
   assign req_gnt = take ? NUM_REQ'(1) << win : '0;
   always_comb begin
      state_d = mmu_flush ? IDLE : take ? LOOKUP : (state_q == LOOKUP) ? RESP :
                (state_q == RESP && rsp_ack) ? IDLE : state_q;
      rr_d    = take ? ((win == 2'd2) ? 2'd0 : win + 2'd1) : rr_q;
      id_d    = take ? win : id_q;
      pa_d    = take ? req_pa[win*PA_W +: PA_W] : pa_q;
      vld_d   = lookup | (vld_q & ~mmu_flush & ~rsp_ack);
      flg_d   = lookup ? sysmap_mmu_flg_y : flg_q;
      hit_d   = lookup ? sysmap_mmu_hit_y : hit_q;
   end
   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         state_q <= IDLE;
         rr_q    <= '0;
         id_q    <= '0;
         pa_q    <= '0;
         vld_q   <= 1'b0;
         flg_q   <= '0;
         hit_q   <= '0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         id_q    <= id_d;
         pa_q    <= pa_d;
         vld_q   <= vld_d;
         flg_q   <= flg_d;
         hit_q   <= hit_d;
      end
   end
   assign mmu_sysmap_pa_y = pa_q;
   assign rsp_vld         = vld_q;
   assign rsp_id          = id_q;
   assign rsp_flg         = flg_q;
   assign rsp_hit         = hit_q;
`ifdef MMU_SYSMAP_MULTIHIT_CHK_EN
   logic err_q, err_d;
   always_comb begin
      err_d = lookup ? ~((|sysmap_mmu_hit_y) &&
                         ((sysmap_mmu_hit_y & (sysmap_mmu_hit_y - HIT_W'(1))) == '0))
                     : err_q & vld_d;
   end
   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) err_q <= 1'b0;
      else           err_q <= err_d;
   end
   assign rsp_err = err_q;
`else
   assign rsp_err = 1'b0;
`endif
endmodule

// File: doc/ct_mmu_sysmap_arb.md
Name: ct_mmu_sysmap_arb

Overview:
- Arbitrates and sequences one shared sysmap attribute-lookup port between three MMU requesters: req0 = PTW, req1 = DTLB refill, req2 = ITLB refill.
- Grants one requester at a time with round-robin priority and drives the latched PA page number to the combinational sysmap block.
- Registers the returned flags and region hit vector, then holds them until the granted requester acknowledges.
- Sits in the MMU top between the TLB-refill/PTW logic and the sysmap comparator bank.

Parameters:
- NUM_REQ, 3, number of requesters (fixed 3 for this revision).
- PA_W, 28, PA page-number width (PA_WIDTH-12).
- FLG_W, 5, sysmap flag width.
- HIT_W, 8, number of sysmap regions.

Ports:
- forever_cpuclk  input  1  clock.
- cpurst_b  input  1  asynchronous reset, active low.
- mmu_flush  input  1  abort the in-flight lookup.
- req_vld  input  3  per-requester request.
- req_pa  input  3*PA_W  per-requester page number; slice i belongs to req i.
- req_gnt  output  3  one-hot grant.
- rsp_vld  output  1  result valid.
- rsp_id  output  2  index of the served requester.
- rsp_flg  output  FLG_W  sysmap flags.
- rsp_hit  output  HIT_W  region hit vector.
- rsp_err  output  1  multi/no-hit error (feature only).
- rsp_ack  input  1  consumer accepts the result.
- mmu_sysmap_pa_y  output  PA_W  to sysmap.
- sysmap_mmu_flg_y  input  FLG_W  from sysmap.
- sysmap_mmu_hit_y  input  HIT_W  from sysmap.

Interface rule: one clock; reset is asynchronous and active-low (forever_cpuclk, cpurst_b).

Behaviour:
- Reset values: state=IDLE, rr_ptr=0, req_gnt=0, rsp_vld=0, rsp_id=0, rsp_flg=0, rsp_hit=0, rsp_err=0, latched pa=0.
- States are IDLE, LOOKUP, RESP.
- IDLE:
  - If any req_vld is set and mmu_flush=0, assert req_gnt combinationally in the same cycle.
  - Winner is the first set req_vld scanning from rr_ptr upward, modulo 3.
  - At the clock edge: latch req_pa of the winner and its id, set rr_ptr=(winner+1)%3, go to LOOKUP.
  - A request is taken only when req_vld and req_gnt are both high. The requester may drop req_vld the cycle after the grant.
- LOOKUP:
  - mmu_sysmap_pa_y = latched pa. This output is driven from the register in every state, so it is stable.
  - At the edge: capture sysmap_mmu_flg_y into rsp_flg and sysmap_mmu_hit_y into rsp_hit, set rsp_vld=1, go to RESP.
- RESP:
  - Hold rsp_* stable while rsp_ack=0.
  - On rsp_ack=1: clear rsp_vld at the edge and go to IDLE.
  - No new grant in the ack cycle. The next grant is no earlier than the cycle after.
- Latency: grant at cycle N, rsp_vld at N+2. Minimum 3 cycles per lookup with immediate ack.
- Flush:
  - mmu_flush=1 suppresses req_gnt in any state.
  - In LOOKUP or RESP, flush forces IDLE at the next edge and clears rsp_vld. No response is delivered for the aborted lookup.
  - rr_ptr is not restored.
- Flush and ack in the same cycle: treated as flush (result discarded, IDLE).
- rsp_ack while rsp_vld=0: ignored.
- req_gnt is never asserted outside IDLE. It is at most one-hot.
- Wrap-around: after serving req2, rr_ptr returns to 0.
- No-hit or multi-hit: rsp_flg passes through whatever sysmap returns (default attribute encoding 5'b10011 for no single hit).

Optional Feature:
- Macro MMU_SYSMAP_MULTIHIT_CHK_EN.
- Defined:
  - In LOOKUP, rsp_err is registered as 1 when sysmap_mmu_hit_y is not exactly one-hot (zero or multiple bits set).
  - rsp_err is held in RESP and cleared with rsp_vld.
- Not defined: rsp_err is tied to 0 and the one-hot check logic is absent.

Test Plan:
- Single request: after reset, req_vld=3'b010, req_pa[1]=28'h0010000, sysmap returns hit=8'h04, flg=5'h0F.
  - req_gnt=3'b010 at cycle N.
  - rsp_vld at N+2 with rsp_id=1, rsp_hit=8'h04, rsp_flg=5'h0F.
  - mmu_sysmap_pa_y=28'h0010000 during LOOKUP.
- Round-robin: req_vld=3'b111 held continuously, ack given the cycle rsp_vld rises. Grants go 0,1,2,0 in order.
- Hold: rsp_ack held low for 5 cycles. rsp_* stays unchanged, req_gnt=0 while req_vld=3'b111. Ack, then a grant resumes the cycle after.
- Flush:
  - mmu_flush in LOOKUP: no rsp_vld, state IDLE next cycle, a new request is granted after flush drops.
  - Flush and ack together in RESP: rsp_vld clears, no double response.
- Reset mid-RESP: cpurst_b low asynchronously. rsp_vld=0 and req_gnt=0 immediately; after release the first grant goes to req0 when req_vld=3'b111.
- With MMU_SYSMAP_MULTIHIT_CHK_EN:
  - hit=8'h06 gives rsp_err=1.
  - hit=8'h00 gives rsp_err=1, rsp_flg=5'b10011.
  - hit=8'h80 gives rsp_err=0.
  - Without the macro, rsp_err stays 0 in all three cases.
